// File: rtl/cal_pkg.sv
// Shared constants, the weekday name table and the serializer state type
// used by the calendar date serializer.
package cal_pkg;

  localparam int          FRAME_LEN   = 10;
  localparam logic [3:0]  LAST_IDX    = 4'(FRAME_LEN - 1);

  localparam logic [7:0]  ASCII_ZERO  = 8'h30;
  localparam logic [7:0]  ASCII_QMARK = 8'h3F;
  localparam logic [7:0]  ASCII_SPACE = 8'h20;

  // Element 0 is SUN; a packed array puts the first-listed entry in the top slot.
  localparam logic [6:0][23:0] DAY_NAMES = {
    "SAT", "FRI", "THU", "WED", "TUE", "MON", "SUN"
  };

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic logic [23:0] day_name(input logic [2:0] day);
    if (day == 3'd7) begin
      return {3{ASCII_QMARK}};
    end
    return DAY_NAMES[day];
  endfunction

endpackage

// File: rtl/cal_date_serializer_if.sv
// Byte stream between the date serializer (master) and a UART/log sink (slave).
interface cal_date_serializer_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/cal_bin2ascii.sv
// Converts a 0..31 value into two ASCII decimal digits; the invalid flag
// replaces both digits with '?'.
module cal_bin2ascii
    import cal_pkg::*;
(
    input  logic [4:0] value_i,
    input  logic       invalid_i,
    output logic [7:0] tens_o,
    output logic [7:0] ones_o
);

    logic [4:0] tens_v;
    logic [4:0] ones_v;

    assign tens_v = value_i / 5'd10;
    assign ones_v = value_i % 5'd10;

    assign tens_o = invalid_i ? ASCII_QMARK : ASCII_ZERO + {3'b000, tens_v};
    assign ones_o = invalid_i ? ASCII_QMARK : ASCII_ZERO + {3'b000, ones_v};

endmodule

// File: rtl/cal_date_serializer.sv
// Sends "DD/MM WWW\n" for the calendar value after reset and on every change,
// over a registered valid/ready byte stream.
module cal_date_serializer
    import cal_pkg::*;
#(
    parameter bit         SEND_ON_RESET = 1'b1,
    parameter logic [7:0] SEP_CHAR      = 8'h2F,
    parameter logic [7:0] EOL_CHAR      = 8'h0A
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [2:0]                   Day,
    input  logic [4:0]                   Date,
    input  logic [3:0]                   Month,
    output logic                         busy,
    cal_date_serializer_if.master        tx
);

    state_e     state_q;
    logic [3:0] idx_q;
    logic [2:0] day_q;
    logic [4:0] date_q;
    logic [3:0] month_q;
    logic       first_q;
    logic       tx_valid_q;
    logic       busy_q;
    logic [7:0] tx_data_q;

    logic [2:0]  src_day;
    logic [4:0]  src_date;
    logic [3:0]  src_month;
    logic        date_invalid;
    logic        month_invalid;
    logic [7:0]  date_tens, date_ones;
    logic [7:0]  month_tens, month_ones;
    logic [23:0] day_chars;
    logic [3:0]  idx_d;
    logic [7:0]  tx_data_d;
    logic        trigger;
    logic        xfer;

    // In IDLE the first byte is built from the live inputs that are being
    // latched on the same edge; in SEND everything comes from the snapshot.
    assign src_day   = (state_q == IDLE) ? Day   : day_q;
    assign src_date  = (state_q == IDLE) ? Date  : date_q;
    assign src_month = (state_q == IDLE) ? Month : month_q;

    assign date_invalid  = (src_date == 5'd0);
    assign month_invalid = (src_month == 4'd0) || (src_month > 4'd12);
    assign day_chars     = day_name(src_day);

    cal_bin2ascii u_date_ascii (
        .value_i   (src_date),
        .invalid_i (date_invalid),
        .tens_o    (date_tens),
        .ones_o    (date_ones)
    );

    cal_bin2ascii u_month_ascii (
        .value_i   ({1'b0, src_month}),
        .invalid_i (month_invalid),
        .tens_o    (month_tens),
        .ones_o    (month_ones)
    );

    assign idx_d   = (state_q == IDLE) ? 4'd0 : idx_q + 4'd1;
    assign trigger = en && (first_q || ({Day, Date, Month} != {day_q, date_q, month_q}));
    assign xfer    = tx_valid_q && tx.tx_ready;

    always_comb begin
        // NOTE: default first so every path assigns tx_data_d and no latch is inferred.
        tx_data_d = EOL_CHAR;
        case (idx_d)
            4'd0:    tx_data_d = date_tens;
            4'd1:    tx_data_d = date_ones;
            4'd2:    tx_data_d = SEP_CHAR;
            4'd3:    tx_data_d = month_tens;
            4'd4:    tx_data_d = month_ones;
            4'd5:    tx_data_d = ASCII_SPACE;
            4'd6:    tx_data_d = day_chars[23:16];
            4'd7:    tx_data_d = day_chars[15:8];
            4'd8:    tx_data_d = day_chars[7:0];
            default: tx_data_d = EOL_CHAR;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            day_q      <= 3'd0;
            date_q     <= 5'd0;
            month_q    <= 4'd0;
            first_q    <= SEND_ON_RESET;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        day_q      <= Day;
                        date_q     <= Date;
                        month_q    <= Month;
                        first_q    <= 1'b0;
                        idx_q      <= 4'd0;
                        tx_data_q  <= tx_data_d;
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (idx_q == LAST_IDX) begin
                            tx_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            idx_q     <= idx_d;
                            tx_data_q <= tx_data_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign busy        = busy_q;

endmodule
